// File: rtl/tmds_pkg.sv
// -----------------------------------------------------------------------------
// tmds_pkg
// Shared definitions for the multi-mode TMDS encoder:
//   - tmds_mode_t : period type carried alongside each pixel
//   - CTRL_CODE   : DVI control-period symbols indexed by {c1,c0}
//   - VGB_CODE    : video guard-band symbols indexed by lane role
//   - DGB_CODE    : data-island guard-band symbol for roles 1 and 2
//   - TERC4_LUT   : TERC4 nibble to 10-bit symbol table
//   - popcount8   : number of ones in a byte
// -----------------------------------------------------------------------------
package tmds_pkg;

    typedef enum logic [2:0] {
        MODE_CTRL   = 3'd0,
        MODE_VIDEO  = 3'd1,
        MODE_VID_GB = 3'd2,
        MODE_DI     = 3'd3,
        MODE_DI_GB  = 3'd4
    } tmds_mode_t;

    localparam logic [9:0] CTRL_CODE [4] = '{
        10'b1101010100,
        10'b0010101011,
        10'b0101010100,
        10'b1010101011
    };

    localparam logic [9:0] VGB_CODE [3] = '{
        10'b1011001100,
        10'b0100110011,
        10'b1011001100
    };

    localparam logic [9:0] DGB_CODE = 10'b0100110011;

    localparam logic [9:0] TERC4_LUT [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] sum;
        sum = 4'd0;
        for (int i = 0; i < 8; i++) begin
            sum = sum + {3'b000, v[i]};
        end
        return sum;
    endfunction

endpackage

// File: rtl/tmds_lane_enc.sv
// -----------------------------------------------------------------------------
// tmds_lane_enc
// One TMDS lane: stage 1 builds the transition-minimised q_m and its balance,
// stage 2 applies DC balancing (video) or selects a fixed/TERC4 symbol.
// Ports:
//   clk   in  1   pixel clock
//   rst   in  1   synchronous active-high reset
//   mode  in  3   period type (tmds_mode_t encoding, 5..7 behave as CTRL)
//   ctrl  in  2   {c1,c0}
//   data  in  8   video byte
//   terc  in  4   TERC4 nibble
//   q     out 10  encoded symbol, registered
// Parameter ROLE (0..2) selects the guard-band flavour of this lane.
// -----------------------------------------------------------------------------
module tmds_lane_enc
    import tmds_pkg::*;
#(
    parameter int unsigned ROLE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] mode,
    input  logic [1:0] ctrl,
    input  logic [7:0] data,
    input  logic [3:0] terc,
    output logic [9:0] q
);

    localparam logic [1:0] ROLE_IDX = ROLE[1:0];

    logic [3:0]        n1_data_s;
    logic              use_xnor_s;
    logic              chain_s;
    logic [8:0]        qm_s;
    logic [3:0]        n1_qm_s;
    logic signed [4:0] diff_s;

    logic [2:0]        mode_r;
    logic [1:0]        ctrl_r;
    logic [3:0]        terc_r;
    logic [8:0]        qm_r;
    logic signed [4:0] diff_r;

    logic [9:0]        q_next_s;
    logic signed [4:0] cnt_next_s;
    logic [9:0]        q_r;
    logic signed [4:0] cnt_r;

    // Stage-1 combinational: XOR/XNOR chain selection and n1-n0 of q_m[7:0]
    always_comb begin
        n1_data_s  = popcount8(data);
        use_xnor_s = (n1_data_s > 4'd4) || ((n1_data_s == 4'd4) && (data[0] == 1'b0));
        qm_s       = 9'd0;
        chain_s    = data[0];
        qm_s[0]    = chain_s;
        for (int i = 1; i < 8; i++) begin
            if (use_xnor_s) begin
                chain_s = ~(chain_s ^ data[i]);
            end else begin
                chain_s = chain_s ^ data[i];
            end
            qm_s[i] = chain_s;
        end
        qm_s[8] = ~use_xnor_s;
        n1_qm_s = popcount8(qm_s[7:0]);
        // n1 - n0 = 2*n1 - 8; the 5-bit wrap yields the correct two's complement
        diff_s  = {n1_qm_s, 1'b0} - 5'd8;
    end

    // Stage-1 register: period type, side-band fields and q_m with its balance
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r <= 3'd0;
            ctrl_r <= 2'd0;
            terc_r <= 4'd0;
            qm_r   <= 9'd0;
            diff_r <= 5'sd0;
        end else begin
            mode_r <= mode;
            ctrl_r <= ctrl;
            terc_r <= terc;
            qm_r   <= qm_s;
            diff_r <= diff_s;
        end
    end

    // Stage-2 combinational: DC balancing for video, fixed symbols otherwise
    always_comb begin
        q_next_s   = CTRL_CODE[0];
        cnt_next_s = 5'sd0;
        case (mode_r)
            MODE_VIDEO: begin
                if ((cnt_r == 5'sd0) || (diff_r == 5'sd0)) begin
                    q_next_s = {~qm_r[8], qm_r[8], (qm_r[8] ? qm_r[7:0] : ~qm_r[7:0])};
                    if (qm_r[8]) begin
                        cnt_next_s = cnt_r + diff_r;
                    end else begin
                        cnt_next_s = cnt_r - diff_r;
                    end
                end else if (((cnt_r > 5'sd0) && (diff_r > 5'sd0)) ||
                             ((cnt_r < 5'sd0) && (diff_r < 5'sd0))) begin
                    // Running disparity and this word lean the same way: invert
                    q_next_s   = {1'b1, qm_r[8], ~qm_r[7:0]};
                    cnt_next_s = cnt_r - diff_r + {3'b000, qm_r[8], 1'b0};
                end else begin
                    q_next_s   = {1'b0, qm_r[8], qm_r[7:0]};
                    cnt_next_s = cnt_r + diff_r - {3'b000, ~qm_r[8], 1'b0};
                end
            end
            MODE_VID_GB: begin
                q_next_s = VGB_CODE[ROLE_IDX];
            end
            MODE_DI: begin
                q_next_s = TERC4_LUT[terc_r];
            end
            MODE_DI_GB: begin
                q_next_s = (ROLE_IDX == 2'd0) ? TERC4_LUT[terc_r] : DGB_CODE;
            end
            default: begin
                // CTRL and the unused encodings 5..7
                q_next_s = CTRL_CODE[ctrl_r];
            end
        endcase
    end

    // Stage-2 register: output symbol and running disparity
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r   <= 10'd0;
            cnt_r <= 5'sd0;
        end else begin
            q_r   <= q_next_s;
            cnt_r <= cnt_next_s;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/tmds_encoder_mc.sv
// -----------------------------------------------------------------------------
// tmds_encoder_mc
// Multi-channel TMDS/HDMI symbol encoder, 2-clock latency, one symbol per lane
// per pixel clock. Lanes are independent apart from the shared period type.
// Ports:
//   clk_i   in  1            pixel clock
//   rst_i   in  1            synchronous active-high reset
//   mode_i  in  3            period type (0 CTRL,1 VIDEO,2 VID_GB,3 DI,4 DI_GB)
//   ctrl_i  in  2*CHANNELS   {c1,c0} per lane
//   data_i  in  8*CHANNELS   video byte per lane
//   terc_i  in  4*CHANNELS   TERC4 nibble per lane
//   q_o     out 10*CHANNELS  encoded symbol per lane
// Lane i takes guard-band role (i mod 3).
// -----------------------------------------------------------------------------
module tmds_encoder_mc
    import tmds_pkg::*;
#(
    parameter int CHANNELS = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [2:0]              mode_i,
    input  logic [2*CHANNELS-1:0]   ctrl_i,
    input  logic [8*CHANNELS-1:0]   data_i,
    input  logic [4*CHANNELS-1:0]   terc_i,
    output logic [10*CHANNELS-1:0]  q_o
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        tmds_lane_enc #(
            .ROLE (i % 3)
        ) u_lane (
            .clk  (clk_i),
            .rst  (rst_i),
            .mode (mode_i),
            .ctrl (ctrl_i[2*i +: 2]),
            .data (data_i[8*i +: 8]),
            .terc (terc_i[4*i +: 4]),
            .q    (q_o[10*i +: 10])
        );
    end

endmodule

// File: tb/tb_tmds_encoder_mc.sv
// -----------------------------------------------------------------------------
// tb_tmds_encoder_mc
// Directed bench for tmds_encoder_mc with six lanes (roles 0,1,2,0,1,2).
// A behavioural lane model computes each expected symbol when the stimulus is
// driven; results queue up and are compared when the DUT emits them.
// -----------------------------------------------------------------------------
module tb_tmds_encoder_mc;

    localparam int CH = 6;

    typedef struct {
        logic [10*CH-1:0] q;
        int               cnt0;
    } exp_t;

    logic               clk;
    logic               rst;
    logic [2:0]         mode;
    logic [2*CH-1:0]    ctrl;
    logic [8*CH-1:0]    data;
    logic [4*CH-1:0]    terc;
    logic [10*CH-1:0]   q;

    exp_t sb[$];
    int   model_cnt [CH];
    int   checks;
    int   failures;

    tmds_encoder_mc #(
        .CHANNELS (CH)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .mode_i (mode),
        .ctrl_i (ctrl),
        .data_i (data),
        .terc_i (terc),
        .q_o    (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference symbol tables written independently of the RTL package
    function automatic int ctrl_sym(int c);
        case (c)
            0:       return 'h354;
            1:       return 'h0AB;
            2:       return 'h154;
            default: return 'h2AB;
        endcase
    endfunction

    function automatic int terc_sym(int n);
        int t [16];
        t = '{'h29C, 'h263, 'h2E4, 'h2E2, 'h171, 'h11E, 'h18E, 'h13C,
              'h2CC, 'h139, 'h19C, 'h2C6, 'h28E, 'h271, 'h163, 'h2C3};
        return t[n];
    endfunction

    function automatic int ones(int v);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) n += (v >> i) & 1;
        return n;
    endfunction

    // Behavioural lane: returns the symbol and advances that lane's disparity
    function automatic int model_lane(int lane, int md, int c, int d, int t);
        int role, n1, xn, b, qm, q8, diff, cv, res;
        role = lane % 3;
        cv   = model_cnt[lane];
        res  = 0;
        if (md == 1) begin
            n1 = ones(d);
            xn = ((n1 > 4) || (n1 == 4 && (d & 1) == 0)) ? 1 : 0;
            b  = d & 1;
            qm = b;
            for (int i = 1; i < 8; i++) begin
                b = (b ^ ((d >> i) & 1));
                if (xn == 1) b = 1 - b;
                qm |= b << i;
            end
            q8   = 1 - xn;
            diff = 2 * ones(qm) - 8;
            if (cv == 0 || diff == 0) begin
                if (q8 == 1) begin
                    res = 256 | qm;
                    cv  = cv + diff;
                end else begin
                    res = 512 | ((~qm) & 255);
                    cv  = cv - diff;
                end
            end else if ((cv > 0 && diff > 0) || (cv < 0 && diff < 0)) begin
                res = 512 | (q8 << 8) | ((~qm) & 255);
                cv  = cv - diff + 2 * q8;
            end else begin
                res = (q8 << 8) | qm;
                cv  = cv + diff - 2 * (1 - q8);
            end
        end else begin
            cv = 0;
            if (md == 2)      res = (role == 1) ? 'h133 : 'h2CC;
            else if (md == 3) res = terc_sym(t);
            else if (md == 4) res = (role == 0) ? terc_sym(t) : 'h133;
            else              res = ctrl_sym(c);
        end
        model_cnt[lane] = cv;
        return res;
    endfunction

    // Drive one clock of stimulus, then compare whatever the DUT emits
    task automatic step(input logic r, input logic [2:0] md, input logic [2*CH-1:0] c,
                        input logic [8*CH-1:0] d, input logic [4*CH-1:0] t, input string tag);
        exp_t e;
        int   obs_cnt;
        rst  = r;
        mode = md;
        ctrl = c;
        data = d;
        terc = t;
        if (!r) begin
            for (int l = 0; l < CH; l++) begin
                e.q[10*l +: 10] = 10'(model_lane(l, int'(md), int'(c[2*l +: 2]),
                                                 int'(d[8*l +: 8]), int'(t[4*l +: 4])));
            end
            e.cnt0 = model_cnt[0];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        obs_cnt = int'(dut.g_lane[0].u_lane.cnt_r);
        if (r) begin
            checks++;
            assert (q === '0) else begin
                failures++;
                $error("FAIL %s q: got %h expected 0", tag, q);
            end
            checks++;
            assert (obs_cnt === 0) else begin
                failures++;
                $error("FAIL %s cnt0: got %0d expected 0", tag, obs_cnt);
            end
            sb.delete();
            for (int l = 0; l < CH; l++) begin
                model_cnt[l] = 0;
                e.q[10*l +: 10] = 10'h354;
            end
            e.cnt0 = 0;
            sb.push_back(e);
        end else if (sb.size() < 2) begin
            checks++;
            failures++;
            $error("FAIL %s scoreboard: got %0d entries expected at least 2", tag, sb.size());
        end else begin
            e = sb.pop_front();
            checks++;
            assert (q === e.q) else begin
                failures++;
                $error("FAIL %s q: got %h expected %h", tag, q, e.q);
            end
            checks++;
            assert (obs_cnt === e.cnt0) else begin
                failures++;
                $error("FAIL %s cnt0: got %0d expected %0d", tag, obs_cnt, e.cnt0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [8*CH-1:0] zeros;
        checks   = 0;
        failures = 0;
        zeros    = '0;
        for (int l = 0; l < CH; l++) model_cnt[l] = 0;

        // Reset held three cycles, then CTRL with lanes 00/01/10 repeating
        for (int i = 0; i < 3; i++) step(1'b1, 3'd0, '0, zeros, '0, "reset");
        step(1'b0, 3'd0, 12'b10_01_00_10_01_00, zeros, '0, "release");

        // Three VIDEO 0x00 words: 0x100, 0x3FF, 0x100 with cnt -8, +2, -6
        for (int i = 0; i < 3; i++) step(1'b0, 3'd1, '0, zeros, '0, "video00");
        // One CTRL word clears disparity, VIDEO 0x00 restarts at -8
        step(1'b0, 3'd0, '0, zeros, '0, "ctrl_gap");
        step(1'b0, 3'd1, '0, zeros, '0, "video_restart");

        // Assorted video bytes including the N1==4 tie-break cases
        step(1'b0, 3'd1, '0, {6{8'hFF}}, '0, "video_ff");
        step(1'b0, 3'd1, '0, {6{8'hAA}}, '0, "video_aa");
        step(1'b0, 3'd1, '0, {6{8'h55}}, '0, "video_55");
        step(1'b0, 3'd1, '0, {8'h01, 8'h80, 8'h0F, 8'hF0, 8'h10, 8'hE7}, '0, "video_mix");
        for (int i = 0; i < 6; i++) begin
            logic [8*CH-1:0] rnd;
            for (int l = 0; l < CH; l++) rnd[8*l +: 8] = 8'($urandom_range(0, 255));
            step(1'b0, 3'd1, '0, rnd, '0, "video_rand");
        end

        // Video guard band across six lanes
        step(1'b0, 3'd2, '0, zeros, '0, "vid_gb");

        // TERC4 sweep on every lane, then data-island guard band
        for (int n = 0; n < 16; n++) begin
            logic [3:0] nib;
            nib = 4'(n);
            step(1'b0, 3'd3, '0, zeros, {6{nib}}, "di_sweep");
        end
        step(1'b0, 3'd4, '0, zeros, {4'h5, 4'h3, 4'hA, 4'h0, 4'h0, 4'hC}, "di_gb");

        // Mid-stream reset with non-zero disparity in flight
        step(1'b0, 3'd1, '0, zeros, '0, "pre_reset_video");
        step(1'b0, 3'd1, '0, zeros, '0, "pre_reset_video2");
        step(1'b1, 3'd1, '0, zeros, '0, "mid_reset");
        step(1'b0, 3'd1, '0, zeros, '0, "post_reset_video");

        // Unused mode 7 behaves as CTRL and clears disparity
        step(1'b0, 3'd1, '0, zeros, '0, "pre_mode7_video");
        step(1'b0, 3'd7, 12'hFFF, zeros, '0, "mode7");
        step(1'b0, 3'd0, '0, zeros, '0, "flush1");
        step(1'b0, 3'd0, '0, zeros, '0, "flush2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
